// File: rtl/ks_pluck_ctrl.sv
// ks_pluck_ctrl: Karplus-Strong voice sequencer (noise burst, ring, damp to muted idle).
// Define KS_NOTE_QUEUE_EN to add a one-entry note buffer that chains bursts back to back.
module ks_pluck_ctrl #(
  parameter int          MIN_PERIOD  = 2,
  parameter int          SUSTAIN_MAX = 48000,
  parameter int          DAMP_STEP   = 8,
  parameter int          DAMP_LEN    = 1024,
  parameter logic [23:0] LFSR_SEED   = 24'h5A5A5A
) (
  input  logic        lrck,
  input  logic        rst,
  input  logic        note_valid,
  output logic        note_ready,
  input  logic [10:0] note_period,
  input  logic [9:0]  note_stretch,
  input  logic [7:0]  note_gain,
  input  logic        note_off,
  output logic        excite,
  output logic [23:0] exc_sample,
  output logic [9:0]  stretch,
  output logic [10:0] period,
  output logic        mute,
  output logic [1:0]  state
);
  localparam int          SW       = $clog2(SUSTAIN_MAX + 1);
  localparam int          DW       = $clog2(DAMP_LEN + 1);
  localparam logic [9:0]  STR_REST = 10'd512;
  localparam logic [23:0] TAPS     = 24'hE10000;
  typedef enum logic [1:0] {IDLE = 2'd0, EXCITE = 2'd1, RING = 2'd2, DAMP = 2'd3} st_t;
  st_t                st_q, st_n;
  logic [23:0]        lfsr_q, lfsr_n;
  logic [10:0]        cnt_q, cnt_n, per_n, sp, per_in, s_up, s_dn;
  logic [SW-1:0]      sus_q, sus_n;
  logic [DW-1:0]      dcnt_q, dcnt_n;
  logic [9:0]         str_n, ss, str_step;
  logic [7:0]         gain_q, gain_n, sg;
  logic               pend_q, pend_n, mute_n, acc, start, rdy_n;
  logic signed [32:0] a, b, prod;
`ifdef KS_NOTE_QUEUE_EN
  logic               qv_q, qv_n;
  logic [10:0]        qper_q, qper_n;
  logic [9:0]         qstr_q, qstr_n;
  logic [7:0]         qgain_q, qgain_n;
`endif
  assign state  = st_q;
  assign lfsr_n = {1'b0, lfsr_q[23:1]} ^ (lfsr_q[0] ? TAPS : 24'd0);
  assign per_in = note_period < 11'(MIN_PERIOD) ? 11'(MIN_PERIOD) : note_period;
  assign s_up   = {1'b0, stretch} + 11'(DAMP_STEP);
  assign s_dn   = {1'b0, stretch} - 11'(DAMP_STEP);
  assign str_step = stretch < STR_REST ? (s_up > 11'd512 ? STR_REST : s_up[9:0])
                                       : (s_dn < 11'd512 ? STR_REST : s_dn[9:0]);
  always_comb begin
    acc    = note_valid && note_ready;
    st_n   = st_q;
    cnt_n  = cnt_q;
    sus_n  = sus_q;
    dcnt_n = dcnt_q;
    per_n  = period;
    gain_n = gain_q;
    pend_n = pend_q;
    str_n  = stretch;
    mute_n = mute;
    start  = acc;
    sp     = per_in;
    ss     = note_stretch;
    sg     = note_gain;
`ifdef KS_NOTE_QUEUE_EN
    qv_n    = qv_q;
    qper_n  = qper_q;
    qstr_n  = qstr_q;
    qgain_n = qgain_q;
`endif
    case (st_q)
      EXCITE: begin
        pend_n = pend_q || (note_off && !acc);
`ifdef KS_NOTE_QUEUE_EN
        // a buffered note takes over the moment the running burst ends
        start = (cnt_q == 11'd0) && (qv_q || acc);
        if (cnt_q == 11'd0 && qv_q) begin
          sp   = qper_q;
          ss   = qstr_q;
          sg   = qgain_q;
          qv_n = 1'b0;
        end else if (acc && cnt_q != 11'd0) begin
          qv_n    = 1'b1;
          qper_n  = per_in;
          qstr_n  = note_stretch;
          qgain_n = note_gain;
        end
`endif
        if (cnt_q != 11'd0) cnt_n = cnt_q - 11'd1;
        else if (pend_n) begin
          st_n   = DAMP;
          dcnt_n = '0;
        end else begin
          st_n  = RING;
          sus_n = '0;
        end
      end
      RING:
        if (note_off || sus_q == SW'(SUSTAIN_MAX - 1)) begin
          st_n   = DAMP;
          dcnt_n = '0;
        end else sus_n = sus_q + SW'(1);
      DAMP:
        if (dcnt_q == DW'(DAMP_LEN - 1)) begin
          st_n   = IDLE;
          mute_n = 1'b1;
          str_n  = STR_REST;
        end else begin
          dcnt_n = dcnt_q + DW'(1);
          str_n  = str_step;
        end
      default: ;
    endcase
    // an accepted note overrides whatever the current state decided, including note_off
    if (start) begin
      st_n   = EXCITE;
      per_n  = sp;
      str_n  = ss;
      gain_n = sg;
      cnt_n  = sp - 11'd1;
      pend_n = 1'b0;
      mute_n = 1'b0;
    end
`ifdef KS_NOTE_QUEUE_EN
    rdy_n = st_n != EXCITE || !qv_n;
`else
    rdy_n = st_n != EXCITE;
`endif
    a    = {{9{lfsr_q[23]}}, lfsr_q};
    b    = {25'd0, gain_n};
    prod = a * b;
  end
  always_ff @(posedge lrck or posedge rst)
    if (rst) begin
      st_q       <= IDLE;
      lfsr_q     <= LFSR_SEED;
      cnt_q      <= '0;
      sus_q      <= '0;
      dcnt_q     <= '0;
      gain_q     <= '0;
      pend_q     <= 1'b0;
      excite     <= 1'b0;
      exc_sample <= '0;
      stretch    <= STR_REST;
      period     <= 11'(MIN_PERIOD);
      mute       <= 1'b1;
      note_ready <= 1'b1;
    end else begin
      st_q       <= st_n;
      lfsr_q     <= lfsr_n;
      cnt_q      <= cnt_n;
      sus_q      <= sus_n;
      dcnt_q     <= dcnt_n;
      gain_q     <= gain_n;
      pend_q     <= pend_n;
      excite     <= st_n == EXCITE;
      exc_sample <= st_n == EXCITE ? 24'(prod >>> 8) : 24'd0;
      stretch    <= str_n;
      period     <= per_n;
      mute       <= mute_n;
      note_ready <= rdy_n;
    end
`ifdef KS_NOTE_QUEUE_EN
  always_ff @(posedge lrck or posedge rst)
    if (rst) begin
      qv_q    <= 1'b0;
      qper_q  <= '0;
      qstr_q  <= '0;
      qgain_q <= '0;
    end else begin
      qv_q    <= qv_n;
      qper_q  <= qper_n;
      qstr_q  <= qstr_n;
      qgain_q <= qgain_n;
    end
`endif
endmodule
